// File: rtl/limn2600_bus_arbiter.sv
// Two-master bus arbiter for the limn2600 memory port.
// Alternating priority on ties, per-access timeout abort, registered outputs.
module limn2600_bus_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic        s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_rdy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        last_q;
    logic        owner_q;
    logic        we_q;
    logic        s_req_q;
    logic        s_we_q;
    logic [31:0] s_addr_q;
    logic [31:0] s_wdata_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic        m0_ack_q;
    logic        m1_ack_q;
    logic        m0_err_q;
    logic        m1_err_q;
    logic [7:0]  cnt_q;

    logic        any_req;
    logic        gnt_d;

    // Pick the master to grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            gnt_d = ~last_q;
        end else begin
            gnt_d = m1_req;
        end
    end

    // Transaction FSM with all bus-facing and master-facing outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            s_req_q    <= 1'b0;
            s_we_q     <= 1'b0;
            s_addr_q   <= 32'd0;
            s_wdata_q  <= 32'd0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q   <= gnt_d;
                        last_q    <= gnt_d;
                        we_q      <= gnt_d ? m1_we : m0_we;
                        s_we_q    <= gnt_d ? m1_we : m0_we;
                        s_addr_q  <= gnt_d ? m1_addr : m0_addr;
                        s_wdata_q <= gnt_d ? m1_wdata : m0_wdata;
                        s_req_q   <= 1'b1;
                        cnt_q     <= 8'd0;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (s_rdy) begin
                        if (!we_q) begin
                            if (owner_q) begin
                                m1_rdata_q <= s_rdata;
                            end else begin
                                m0_rdata_q <= s_rdata;
                            end
                        end
                        m0_ack_q <= ~owner_q;
                        m1_ack_q <= owner_q;
                        s_req_q  <= 1'b0;
                        s_we_q   <= 1'b0;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == CNT_LAST) begin
                            m0_err_q <= ~owner_q;
                            m1_err_q <= owner_q;
                            s_req_q  <= 1'b0;
                            s_we_q   <= 1'b0;
                            state_q  <= RESP;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
    assign s_req    = s_req_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_limn2600_bus_arbiter.sv
// Directed bench for limn2600_bus_arbiter with a response scoreboard.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_limn2600_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m1_req;
    logic        m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        m0_err, m1_err;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata;
    logic        s_rdy;
    logic        owner;

    logic        use_mem;
    logic [31:0] rdata_drv;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        m;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    limn2600_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .m0_we    (m0_we),
        .m1_we    (m1_we),
        .m0_addr  (m0_addr),
        .m1_addr  (m1_addr),
        .m0_wdata (m0_wdata),
        .m1_wdata (m1_wdata),
        .m0_rdata (m0_rdata),
        .m1_rdata (m1_rdata),
        .m0_ack   (m0_ack),
        .m1_ack   (m1_ack),
        .m0_err   (m0_err),
        .m1_err   (m1_err),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .s_rdy    (s_rdy),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in: either a fixed value or an address-derived pattern.
    always_comb begin
        s_rdata = rdata_drv;
        if (use_mem) s_rdata = s_addr + 32'h1000_0000;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Scoreboard consumer: every ack/err pulse must match the oldest expectation.
    exp_t e;
    logic obs_m;
    always @(negedge clk) begin
        if (!rst && (m0_ack || m0_err || m1_ack || m1_err)) begin
            chk("resp_onehot", 32'(m0_ack) + 32'(m0_err) + 32'(m1_ack) + 32'(m1_err), 32'd1);
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                obs_m = m1_ack | m1_err;
                chkb("resp_master", obs_m, e.m);
                chkb("resp_err", m0_err | m1_err, e.err);
                chk("resp_rdata", obs_m ? m1_rdata : m0_rdata, e.rdata);
            end
        end
    end

    initial begin
        rst = 1'b1;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        s_rdy = 0; use_mem = 0; rdata_drv = 0;
        step(); step();
        rst = 1'b0;

        // reset values
        chkb("rst_s_req", s_req, 1'b0);
        chkb("rst_s_we", s_we, 1'b0);
        chkb("rst_owner", owner, 1'b0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chkb("rst_m0_ack", m0_ack | m0_err, 1'b0);

        // single read by m0
        m0_req = 1; m0_we = 0; m0_addr = 32'h100;
        sb.push_back('{m: 1'b0, err: 1'b0, rdata: 32'hDEADBEEF});
        step();
        chkb("rd_s_req", s_req, 1'b1);
        chk("rd_s_addr", s_addr, 32'h100);
        chkb("rd_s_we", s_we, 1'b0);
        chkb("rd_owner", owner, 1'b0);
        m0_req = 0;
        s_rdy = 1; rdata_drv = 32'hDEADBEEF;
        step();
        s_rdy = 0;
        chkb("rd_ack_t2", m0_ack, 1'b1);
        chkb("rd_s_req_off", s_req, 1'b0);
        chk("rd_m1_rdata", m1_rdata, 32'd0);
        chkb("rd_m1_ack", m1_ack | m1_err, 1'b0);
        step();
        chkb("rd_ack_gone", m0_ack, 1'b0);
        chkb("rd_idle_s_req", s_req, 1'b0);
        chk("rd_hold", m0_rdata, 32'hDEADBEEF);

        // reset again so the tie starts from last = 1
        rst = 1; step(); rst = 0;
        chk("rst2_m0_rdata", m0_rdata, 32'd0);

        // tie: both hold req, grants alternate m0, m1, m0; s_rdy held high throughout
        use_mem = 1; s_rdy = 1;
        m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
        m0_addr = 32'h200; m1_addr = 32'h300;
        sb.push_back('{m: 1'b0, err: 1'b0, rdata: 32'h1000_0200});
        sb.push_back('{m: 1'b1, err: 1'b0, rdata: 32'h1000_0300});
        sb.push_back('{m: 1'b0, err: 1'b0, rdata: 32'h1000_0200});
        for (int k = 0; k < 3; k++) begin
            step();
            chkb("tie_s_req", s_req, 1'b1);
            chkb("tie_owner", owner, 1'(k % 2));
            chk("tie_s_addr", s_addr, (k % 2 == 1) ? 32'h300 : 32'h200);
            step();
            if (k == 2) begin
                m0_req = 0; m1_req = 0;
            end
            step();
        end
        chkb("tie_idle", s_req, 1'b0);
        chk("tie_m0_rdata", m0_rdata, 32'h1000_0200);
        chk("tie_m1_rdata", m1_rdata, 32'h1000_0300);
        s_rdy = 0; use_mem = 0;

        // write by m1 leaves m1_rdata alone
        m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h12345678;
        rdata_drv = 32'hFFFF_FFFF;
        sb.push_back('{m: 1'b1, err: 1'b0, rdata: 32'h1000_0300});
        step();
        chkb("wr_s_we", s_we, 1'b1);
        chk("wr_s_addr", s_addr, 32'h40);
        chk("wr_s_wdata", s_wdata, 32'h12345678);
        chkb("wr_owner", owner, 1'b1);
        m1_req = 0; s_rdy = 1;
        step();
        s_rdy = 0;
        chkb("wr_resp_s_we", s_we, 1'b0);
        step();
        chkb("wr_idle_s_we", s_we, 1'b0);
        chk("wr_addr_hold", s_addr, 32'h40);
        chk("wr_wdata_hold", s_wdata, 32'h12345678);
        m1_we = 0;

        // timeout: four ACCESS cycles then m0_err
        m0_req = 1; m0_addr = 32'h500;
        sb.push_back('{m: 1'b0, err: 1'b1, rdata: 32'h1000_0200});
        for (int k = 0; k < 4; k++) begin
            step();
            chkb("to_s_req", s_req, 1'b1);
            m0_req = 0;
        end
        step();
        chkb("to_err", m0_err, 1'b1);
        chkb("to_s_req_off", s_req, 1'b0);
        step();
        chkb("to_err_gone", m0_err | m0_ack, 1'b0);
        chkb("to_idle", s_req, 1'b0);

        // s_rdy on the timeout cycle wins
        m0_req = 1; m0_addr = 32'h600; rdata_drv = 32'hCAFEF00D;
        sb.push_back('{m: 1'b0, err: 1'b0, rdata: 32'hCAFEF00D});
        for (int k = 0; k < 4; k++) begin
            step();
            chkb("col_s_req", s_req, 1'b1);
            m0_req = 0;
            if (k == 3) s_rdy = 1;
        end
        step();
        s_rdy = 0;
        chkb("col_ack", m0_ack, 1'b1);
        chkb("col_no_err", m0_err, 1'b0);
        step();

        // reset in the second ACCESS cycle
        m1_req = 1; m1_addr = 32'h700;
        step();
        chkb("rm_s_req", s_req, 1'b1);
        m1_req = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        chkb("rm_s_req", s_req, 1'b0);
        chkb("rm_s_we", s_we, 1'b0);
        chkb("rm_owner", owner, 1'b0);
        chk("rm_s_addr", s_addr, 32'd0);
        chk("rm_m0_rdata", m0_rdata, 32'd0);
        chk("rm_m1_rdata", m1_rdata, 32'd0);
        chkb("rm_resp", m0_ack | m0_err | m1_ack | m1_err, 1'b0);
        step();
        chkb("rm_resp2", m0_ack | m0_err | m1_ack | m1_err, 1'b0);
        chkb("rm_s_req2", s_req, 1'b0);
        step();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
